// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer: range-checks multiply/divide requests, drives a PLL reconfig scan and reports lock status.
// Define PLL_SEQ_TIMEOUT_EN to bound the time spent in WAIT_DONE+WAIT_LOCK by TIMEOUT_CYCLES.
module pll_reconfig_sequencer #(
  parameter int DEFAULT_MULT = 1,
  parameter int DEFAULT_DIV = 1,
  parameter int BUSY_START_MAX = 16,
  parameter int LOCK_STABLE_CYCLES = 256
`ifdef PLL_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_mult,
  input  logic [7:0] req_div,
  output logic [7:0] MultiFactor,
  output logic [7:0] DividFactor,
  output logic       trigger,
  input  logic       busy,
  input  logic       locked,
  output logic       active,
  output logic       done,
  output logic [1:0] status
);
  localparam int BW = $clog2(BUSY_START_MAX + 1);
  localparam int LW = $clog2(LOCK_STABLE_CYCLES + 1);
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`endif
  typedef enum logic [2:0] {IDLE, CHECK, TRIG, WAIT_BUSY, WAIT_DONE, WAIT_LOCK, REPORT} state_t;
  state_t state;
  logic [7:0] mult_q, div_q;
  logic [1:0] code;
  logic [1:0] sync;
  logic [BW-1:0] busy_cnt;
  logic [LW-1:0] lock_cnt;
  assign req_ready = state == IDLE && !reset;
  assign active = state != IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      mult_q <= '0;
      div_q <= '0;
      code <= 2'b00;
      sync <= 2'b00;
      busy_cnt <= '0;
      lock_cnt <= '0;
      MultiFactor <= 8'(DEFAULT_MULT);
      DividFactor <= 8'(DEFAULT_DIV);
      trigger <= 1'b0;
      done <= 1'b0;
      status <= 2'b00;
`ifdef PLL_SEQ_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      sync <= {sync[0], locked};
      trigger <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          mult_q <= req_mult;
          div_q <= req_div;
          state <= CHECK;
        end
        CHECK: if (mult_q == 8'd0 || div_q == 8'd0) begin
          code <= 2'b01;
          state <= REPORT;
        end else begin
          MultiFactor <= mult_q;
          DividFactor <= div_q;
          state <= TRIG;
        end
        // factors were loaded a cycle earlier, so they are settled when trigger rises
        TRIG: begin
          trigger <= 1'b1;
          busy_cnt <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (busy) begin
          state <= WAIT_DONE;
`ifdef PLL_SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end else if (busy_cnt == BW'(BUSY_START_MAX - 1)) begin
          code <= 2'b10;
          state <= REPORT;
        end else busy_cnt <= busy_cnt + 1'b1;
        WAIT_DONE: if (!busy) begin
          lock_cnt <= '0;
          state <= WAIT_LOCK;
        end
        WAIT_LOCK: if (!sync[1]) lock_cnt <= '0;
        else if (lock_cnt == LW'(LOCK_STABLE_CYCLES - 1)) begin
          lock_cnt <= LW'(LOCK_STABLE_CYCLES);
          code <= 2'b00;
          state <= REPORT;
        end else lock_cnt <= lock_cnt + 1'b1;
        REPORT: begin
          done <= 1'b1;
          status <= code;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef PLL_SEQ_TIMEOUT_EN
      // placed after the case so a timeout overrides a lock that completes on the same edge
      if (state == WAIT_DONE || state == WAIT_LOCK) begin
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          code <= 2'b11;
          state <= REPORT;
        end else tmo_cnt <= tmo_cnt + 1'b1;
      end
`endif
    end
  end
endmodule
